// File: rtl/vq_speaker_classifier_if.sv
// Handshake between the speaker classifier (master) and the external VQ
// distance engine (slave): one start pulse per codebook, one done pulse back.
interface vq_speaker_classifier_if #(
  parameter int IDX_W   = 4,
  parameter int D_WIDTH = 41
);
  logic               eng_start;
  logic [IDX_W-1:0]   eng_cb_sel;
  logic               eng_done;
  logic [D_WIDTH-1:0] eng_dist;

  modport master (output eng_start, eng_cb_sel, input eng_done, eng_dist);
  modport slave  (input eng_start, eng_cb_sel, output eng_done, eng_dist);
endinterface

// File: rtl/vq_speaker_classifier.sv
// Scores every enrolled codebook through the distance engine, tracks the best and
// runner-up distortion on the fly, and reports the winner or a rejection.
module vq_speaker_classifier #(
  parameter int NUM_SPK = 4,
  parameter int IDX_W   = 4,
  parameter int D_WIDTH = 41
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_start,
  input  logic                    id_abort,
  input  logic [D_WIDTH-1:0]      thresh,
  input  logic [D_WIDTH-1:0]      min_margin,
  vq_speaker_classifier_if.master eng,
  output logic                    busy,
  output logic                    id_valid,
  output logic [IDX_W-1:0]        id_index,
  output logic [NUM_SPK-1:0]      id_onehot,
  output logic                    id_reject,
  output logic [D_WIDTH-1:0]      best_dist
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DECIDE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPK - 1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_best_idx;
  logic [D_WIDTH-1:0]   r_best;
  logic [D_WIDTH-1:0]   r_second;
  logic                 r_eng_start;
  logic                 r_busy;
  logic                 r_id_valid;
  logic [IDX_W-1:0]     r_id_index;
  logic [NUM_SPK-1:0]   r_id_onehot;
  logic                 r_id_reject;
  logic [D_WIDTH-1:0]   r_best_dist;

  logic [D_WIDTH-1:0]   w_margin;
  logic                 w_reject;
  logic [NUM_SPK-1:0]   w_onehot;

  // second >= best always holds, so the unsigned difference never wraps.
  assign w_margin = r_second - r_best;
  assign w_reject = (r_best > thresh) || ((NUM_SPK > 1) && (w_margin < min_margin));
  assign w_onehot = w_reject ? '0 : (NUM_SPK'(1) << r_best_idx);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_best_idx  <= '0;
      r_best      <= '1;
      r_second    <= '1;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_id_valid  <= 1'b0;
      r_id_index  <= '0;
      r_id_onehot <= '0;
      r_id_reject <= 1'b0;
      r_best_dist <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_id_valid  <= 1'b0;
      if (id_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (id_start) begin
              r_cnt       <= '0;
              r_best_idx  <= '0;
              r_best      <= '1;
              r_second    <= '1;
              r_eng_start <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end
          S_LAUNCH: r_state <= S_WAIT;
          S_WAIT: begin
            if (eng.eng_done) begin
              // Strict compares: a tie never displaces the earlier index.
              if (eng.eng_dist < r_best) begin
                r_second   <= r_best;
                r_best     <= eng.eng_dist;
                r_best_idx <= r_cnt;
              end else if (eng.eng_dist < r_second) begin
                r_second <= eng.eng_dist;
              end
              if (r_cnt == LAST_IDX) begin
                r_state <= S_DECIDE;
              end else begin
                r_cnt       <= r_cnt + IDX_W'(1);
                r_eng_start <= 1'b1;
                r_state     <= S_LAUNCH;
              end
            end
          end
          S_DECIDE: begin
            r_id_index  <= r_best_idx;
            r_best_dist <= r_best;
            r_id_reject <= w_reject;
            r_id_onehot <= w_onehot;
            r_id_valid  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign eng.eng_start  = r_eng_start;
  assign eng.eng_cb_sel = r_cnt;
  assign busy           = r_busy;
  assign id_valid       = r_id_valid;
  assign id_index       = r_id_index;
  assign id_onehot      = r_id_onehot;
  assign id_reject      = r_id_reject;
  assign best_dist      = r_best_dist;

endmodule
